// File: rtl/bullet_engine_pkg.sv
// bullet_engine_pkg: field geometry and bullet slot layout shared by the Raiden
// blocks (bullet engine, enemy, dot-matrix scanner).
package bullet_engine_pkg;

    localparam int FIELD_ROWS    = 8;
    localparam int FIELD_COLS    = 16;
    localparam int LANE_W        = 3;
    localparam int COL_W         = 4;
    localparam int DEF_ENEMY_COL = 15;
    localparam int MAP_W         = FIELD_ROWS * FIELD_COLS;

    typedef struct packed {
        logic              active;
        logic [LANE_W-1:0] row;
        logic [COL_W-1:0]  col;
    } slot_t;

    // Enemy sprite covers centre-1..centre+1, clipped to the field edges.
    function automatic logic in_span(input logic [LANE_W-1:0] row,
                                     input logic [LANE_W-1:0] centre);
        logic [LANE_W:0] lo;
        logic [LANE_W:0] hi;
        lo = (centre == '0) ? '0 : {1'b0, centre} - 1'b1;
        hi = {1'b0, centre} + 1'b1;
        return ({1'b0, row} >= lo) && ({1'b0, row} <= hi);
    endfunction

endpackage

// File: rtl/bullet_engine_tick_gen.sv
// bullet_engine_tick_gen: free-running game-tick divider; one-clk strobe every DIV
// clocks. Generic enough for the Enemy block to reuse as its divider.
module bullet_engine_tick_gen #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bullet_engine.sv
// bullet_engine: player-shot manager - spawns, advances and retires bullets, scores hits.
// Define AUTO_FIRE_EN to repeat shots every AUTO_PERIOD ticks while fire is held.
module bullet_engine
    import bullet_engine_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int NUM_SLOTS   = 4,
    parameter int ENEMY_COL   = DEF_ENEMY_COL,
    parameter int AUTO_PERIOD = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fire,
    input  logic [LANE_W-1:0] player_pos,
    input  logic [LANE_W-1:0] enemy_pos,
    output logic              hit,
    output logic [7:0]        score,
    output logic [2:0]        busy_slots,
    output logic [MAP_W-1:0]  bullet_map
);

    localparam logic [COL_W-1:0] ENEMY_C = COL_W'(ENEMY_COL);
    localparam logic [COL_W-1:0] SPAWN_C = COL_W'(1);

    if (NUM_SLOTS < 1 || NUM_SLOTS > 8 || AUTO_PERIOD < 1 ||
        ENEMY_COL < 2 || ENEMY_COL >= FIELD_COLS) begin : g_param_check
        $error("bullet_engine: parameter out of range");
    end

    logic fire_s1_q;
    logic fire_s2_q;
    logic fire_prev_q;
    logic fire_edge;
    logic fire_req;
    logic tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fire_s1_q   <= 1'b0;
            fire_s2_q   <= 1'b0;
            fire_prev_q <= 1'b0;
        end else begin
            fire_s1_q   <= fire;
            fire_s2_q   <= fire_s1_q;
            fire_prev_q <= fire_s2_q;
        end
    end

    assign fire_edge = fire_s2_q & ~fire_prev_q;

    bullet_engine_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst),
        .tick  (tick)
    );

`ifdef AUTO_FIRE_EN
    localparam int                AUTO_W    = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

    logic [AUTO_W-1:0] auto_cnt_q;
    logic [AUTO_W-1:0] auto_cnt_d;
    logic              auto_req;

    // Counts ticks since the press edge (or the last repeat) while the button stays down.
    always_comb begin
        auto_cnt_d = auto_cnt_q;
        auto_req   = 1'b0;
        if (!fire_s2_q || fire_edge) begin
            auto_cnt_d = '0;
        end else if (tick) begin
            if (auto_cnt_q == AUTO_LAST) begin
                auto_req   = 1'b1;
                auto_cnt_d = '0;
            end else begin
                auto_cnt_d = auto_cnt_q + AUTO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end

    assign fire_req = fire_edge | auto_req;
`else
    assign fire_req = fire_edge;
`endif

    slot_t                slot_q [NUM_SLOTS];
    slot_t                slot_d [NUM_SLOTS];
    slot_t                moved  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] hit_vec;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        logic [COL_W-1:0] col_next;
        logic             advance;
        logic             retire;

        assign col_next   = slot_q[i].col + COL_W'(1);
        assign advance    = tick && slot_q[i].active;
        assign retire     = advance && (col_next == ENEMY_C);
        assign hit_vec[i] = retire && in_span(slot_q[i].row, enemy_pos);
        assign moved[i]   = retire  ? slot_t'('0) :
                            advance ? slot_t'({1'b1, slot_q[i].row, col_next}) :
                                      slot_q[i];
    end

    logic spawn_ok;
    logic spawn_done;

    // Spawn sees the post-move field, so a slot retired this tick is reusable at once.
    always_comb begin
        slot_d     = moved;
        spawn_ok   = fire_req;
        spawn_done = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (moved[i].active && moved[i].row == player_pos && moved[i].col == SPAWN_C) begin
                spawn_ok = 1'b0;
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (spawn_ok && !spawn_done && !moved[i].active) begin
                slot_d[i]  = '{active: 1'b1, row: player_pos, col: SPAWN_C};
                spawn_done = 1'b1;
            end
        end
    end

    logic [MAP_W-1:0] map_d;
    logic [3:0]       busy_cnt;
    logic [2:0]       busy_d;
    logic [3:0]       hit_cnt;
    logic [8:0]       score_sum;
    logic [7:0]       score_d;
    logic             hit_d;
    logic [MAP_W-1:0] map_q;
    logic [2:0]       busy_q;
    logic [7:0]       score_q;
    logic             hit_q;

    always_comb begin
        map_d    = '0;
        busy_cnt = '0;
        hit_cnt  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_d[i].active) begin
                map_d[{slot_d[i].row, slot_d[i].col}] = 1'b1;
                busy_cnt = busy_cnt + 4'd1;
            end
            hit_cnt = hit_cnt + {3'b000, hit_vec[i]};
        end
        busy_d    = (busy_cnt > 4'd7) ? 3'd7 : busy_cnt[2:0];
        score_sum = {1'b0, score_q} + {5'b00000, hit_cnt};
        score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
        hit_d     = |hit_vec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            map_q   <= '0;
            busy_q  <= '0;
            score_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            map_q   <= map_d;
            busy_q  <= busy_d;
            score_q <= score_d;
            hit_q   <= hit_d;
        end
    end

    assign bullet_map = map_q;
    assign busy_slots = busy_q;
    assign score      = score_q;
    assign hit        = hit_q;

endmodule

// File: tb/tb_bullet_engine.sv
// tb_bullet_engine: directed stimulus with a hit scoreboard for bullet_engine (TICK_DIV=4).
module tb_bullet_engine;

    localparam int TD   = 4;
    localparam int ECOL = 15;

    logic         clk        = 1'b0;
    logic         rst        = 1'b0;
    logic         fire       = 1'b0;
    logic [2:0]   player_pos = 3'd0;
    logic [2:0]   enemy_pos  = 3'd0;
    logic         hit;
    logic [7:0]   score;
    logic [2:0]   busy_slots;
    logic [127:0] bullet_map;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int score;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int   trk_lane   = 0;
    int   peak_busy  = 0;
    int   spawn_cnt  = 0;
    int   last_spawn = -1;
    logic col1_prev  = 1'b0;

    bullet_engine #(
        .TICK_DIV    (TD),
        .NUM_SLOTS   (4),
        .ENEMY_COL   (ECOL),
        .AUTO_PERIOD (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fire       (fire),
        .player_pos (player_pos),
        .enemy_pos  (enemy_pos),
        .hit        (hit),
        .score      (score),
        .busy_slots (busy_slots),
        .bullet_map (bullet_map)
    );

    always #5 clk = ~clk;

    // Mirrors the free-running tick counter: tick updates land on edges where cyc % TD == 0.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && hit === 1'b1) begin
            total++;
            assert (sb_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_hit cyc=%0d score=%0d expected no hit", cyc, score);
            end
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                total++;
                assert (cyc === mon_e.cyc) else begin
                    bad++;
                    $error("FAIL hit_cycle observed=%0d expected=%0d", cyc, mon_e.cyc);
                end
                total++;
                assert (int'(score) === mon_e.score) else begin
                    bad++;
                    $error("FAIL hit_score observed=%0d expected=%0d", score, mon_e.score);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (int'(busy_slots) > peak_busy) peak_busy = int'(busy_slots);
        if (bullet_map[trk_lane*16+1] === 1'b1 && col1_prev === 1'b0) begin
            spawn_cnt++;
            last_spawn = cyc;
        end
        col1_prev = bullet_map[trk_lane*16+1];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int c, input int s);
        exp_t e;
        e.cyc   = c;
        e.score = s;
        sb_q.push_back(e);
    endtask

    function automatic int next_tick(input int s);
        return ((s / TD) + 1) * TD;
    endfunction

    // Spawned at col 1; the 14th tick after the spawn edge lands it on col 15.
    function automatic int hit_edge(input int s);
        return next_tick(s) + (ECOL - 2) * TD;
    endfunction

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) begin
            total++;
            bad++;
            $error("FAIL wait_timeout observed=%0d expected=%0d", cyc, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        fire = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic press(input logic [2:0] lane, output int s);
        player_pos = lane;
        fire       = 1'b1;
        s          = cyc + 3;
        repeat (3) @(negedge clk);
        fire = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Two shots whose spawn edges share one tick interval, so they hit on the same tick.
    task automatic pair_shot(input logic [2:0] la, input logic [2:0] lb,
                             input int exp_score, output int s);
        int guard;
        guard = 0;
        while ((cyc % TD) != 1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        player_pos = la;
        fire       = 1'b1;
        s          = cyc + 3;
        @(negedge clk);
        fire = 1'b0;
        @(negedge clk);
        fire = 1'b1;
        @(negedge clk);
        player_pos = lb;
        @(negedge clk);
        fire = 1'b0;
        @(negedge clk);
        sb_push(hit_edge(s), exp_score);
    endtask

    initial begin
        int s;
        int s2;
        int h;
        int sk [5];
        int exp_sc;

        // Reset mid-flight with two bullets in the air
        do_reset();
        enemy_pos = 3'd7;
        press(3'd0, s);
        press(3'd1, s);
        check("t1_busy_pre", busy_slots, 3'd2);
        check("t1_bits_pre", $countones(bullet_map), 2);
        #3 rst = 1'b0;
        @(negedge clk);
        check("t1_map_rst", bullet_map, '0);
        check("t1_busy_rst", busy_slots, 3'd0);
        check("t1_score_rst", score, 8'd0);
        check("t1_hit_rst", hit, 1'b0);
        rst = 1'b1;

        // Straight hit in lane 3
        do_reset();
        enemy_pos  = 3'd3;
        player_pos = 3'd3;
        fire       = 1'b1;
        s          = cyc + 3;
        repeat (2) @(negedge clk);
        check("t2_lat_2clk", bullet_map[3*16+1], 1'b0);
        @(negedge clk);
        check("t2_lat_3clk", bullet_map[3*16+1], 1'b1);
        fire = 1'b0;
        h = hit_edge(s);
        sb_push(h, 1);
        wait_cyc(h - 1);
        check("t2_col14", bullet_map[3*16+14], 1'b1);
        check("t2_busy_fly", busy_slots, 3'd1);
        wait_cyc(h);
        check("t2_busy_done", busy_slots, 3'd0);
        check("t2_map_done", bullet_map, '0);
        check("t2_score", score, 8'd1);
        wait_cyc(h + 2);

        // Clipped span at the top edge: lane 1 hits, lane 2 misses
        do_reset();
        enemy_pos = 3'd0;
        press(3'd1, s);
        sb_push(hit_edge(s), 1);
        press(3'd2, s2);
        h = hit_edge(s2);
        wait_cyc(h - 1);
        check("t3_lane2_col14", bullet_map[2*16+14], 1'b1);
        wait_cyc(h);
        check("t3_busy", busy_slots, 3'd0);
        check("t3_map", bullet_map, '0);
        check("t3_score", score, 8'd1);
        wait_cyc(h + 2);

        // All slots full: fifth shot dropped
        do_reset();
        enemy_pos = 3'd5;
        trk_lane  = 5;
        col1_prev = 1'b0;
        peak_busy = 0;
        spawn_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            press(3'd5, sk[k]);
            if (k < 4) sb_push(hit_edge(sk[k]), k + 1);
            repeat (2) @(negedge clk);
        end
        check("t4_busy_full", busy_slots, 3'd4);
        h = hit_edge(sk[3]);
        wait_cyc(h + 1);
        check("t4_busy_end", busy_slots, 3'd0);
        check("t4_score", score, 8'd4);
        check("t4_peak_busy", peak_busy, 4);
        check("t4_spawns", spawn_cnt, 4);

        // Simultaneous double hit
        do_reset();
        enemy_pos = 3'd3;
        pair_shot(3'd2, 3'd4, 2, s);
        check("t5_bit_l2", bullet_map[2*16+1], 1'b1);
        check("t5_bit_l4", bullet_map[4*16+1], 1'b1);
        check("t5_bits", $countones(bullet_map), 2);
        h = hit_edge(s);
        wait_cyc(h + 2);
        check("t5_score", score, 8'd2);
        check("t5_busy", busy_slots, 3'd0);

        // Fire held for 10 ticks
        do_reset();
        enemy_pos  = 3'd7;
        trk_lane   = 0;
        col1_prev  = 1'b0;
        spawn_cnt  = 0;
        last_spawn = -1;
        player_pos = 3'd0;
        fire       = 1'b1;
        s          = cyc + 3;
        repeat (10 * TD) @(negedge clk);
        fire = 1'b0;
        repeat (2 * TD) @(negedge clk);
`ifdef AUTO_FIRE_EN
        check("t6_spawns", spawn_cnt, 4);
        check("t6_last_spawn", last_spawn, next_tick(s) + 8 * TD);
`else
        check("t6_spawns", spawn_cnt, 1);
        check("t6_last_spawn", last_spawn, s);
`endif

        // Saturation: 127 double hits reach 254, the next pair clips at 255
        do_reset();
        enemy_pos = 3'd3;
        for (int k = 1; k <= 129; k++) begin
            exp_sc = (2 * k > 255) ? 255 : 2 * k;
            pair_shot(3'd2, 3'd4, exp_sc, s);
            wait_cyc(hit_edge(s) + 1);
            if (k == 127) check("sat_254", score, 8'd254);
        end
        check("sat_255", score, 8'd255);

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
